// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned MD_CNT_W = 4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // E-stage ALU operand select; the M-stage result wins over W, r0 is never forwarded.
  function automatic fwd_sel_t fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             rw_m,
    input logic [REG_W-1:0] wr_m,
    input logic             rw_w,
    input logic [REG_W-1:0] wr_w
  );
    if (src != REG_ZERO && rw_m && wr_m == src)      return FWD_MEM;
    else if (src != REG_ZERO && rw_w && wr_w == src) return FWD_WB;
    else                                             return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_tracker.sv
// Busy tracker for the multi-cycle mult/div unit: IDLE/BUSY FSM with a down-counter.
module muldiv_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MulDivStartE,
  output logic MulDivBusy
);

  md_state_t             r_state;
  md_state_t             w_state_nxt;
  logic [MD_CNT_W-1:0]   r_cnt;
  logic [MD_CNT_W-1:0]   w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A start while BUSY is ignored; the D-stage stall keeps it from happening.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (MulDivStartE) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = MD_CNT_W'(MULDIV_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (r_cnt == '0) w_state_nxt = MD_IDLE;
        else             w_cnt_nxt   = r_cnt - MD_CNT_W'(1);
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    MulDivBusy = (r_state == MD_BUSY);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: stalls, flush and forwarding selects.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             MulDivStartE,
  input  logic             MulDivUseD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MulDivBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] MulDivOps
`endif
);

  if (MULDIV_LAT < 1 || MULDIV_LAT > 15 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: MULDIV_LAT must be 1..15 and CNT_W at least 1");
  end

  logic w_lwstall;
  logic w_branchstall;
  logic w_muldivstall;
  logic w_stall;
  logic w_hit_e;
  logic w_hit_m;

  muldiv_tracker #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_muldiv_tracker (
    .clk          (clk),
    .reset        (reset),
    .MulDivStartE (MulDivStartE),
    .MulDivBusy   (MulDivBusy)
  );

  // Stall causes simply OR together; a start in E counts so a back-to-back use waits.
  always_comb begin
    w_hit_e       = RegWriteE && WriteRegE != REG_ZERO && (WriteRegE == RsD || WriteRegE == RtD);
    w_hit_m       = MemtoRegM && WriteRegM != REG_ZERO && (WriteRegM == RsD || WriteRegM == RtD);
    w_lwstall     = MemtoRegE && (RtE == RsD || RtE == RtD);
    w_branchstall = BranchD && (w_hit_e || w_hit_m);
    w_muldivstall = MulDivUseD && (MulDivBusy || MulDivStartE);
    w_stall       = w_lwstall || w_branchstall || w_muldivstall;
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!reset) begin
      StallF    = w_stall;
      StallD    = w_stall;
      FlushE    = w_stall;
      ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardAD = RsD != REG_ZERO && RegWriteM && WriteRegM == RsD;
      ForwardBD = RtD != REG_ZERO && RegWriteM && WriteRegM == RtD;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_muldiv_ops;
  logic             w_md_launch;

  // IDLE->BUSY happens exactly when a start arrives while the unit is idle.
  always_comb begin
    w_md_launch = MulDivStartE && !MulDivBusy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_muldiv_ops   <= '0;
    end else begin
      if (StallD && r_stall_cycles != '1)    r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_md_launch && r_muldiv_ops != '1) r_muldiv_ops   <= r_muldiv_ops + CNT_W'(1);
    end
  end

  assign StallCycles = r_stall_cycles;
  assign MulDivOps   = r_muldiv_ops;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expected outputs queued per step and checked on the falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, MulDivStartE, MulDivUseD;
  logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MulDivBusy;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, MulDivOps;
  logic [1:0]  StallCycles2, MulDivOps2;
  logic        s2f, s2d, f2e, f2ad, f2bd, busy2;
  logic [1:0]  f2ae, f2be;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MulDivStartE(MulDivStartE), .MulDivUseD(MulDivUseD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MulDivBusy(MulDivBusy)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(StallCycles), .MulDivOps(MulDivOps)
`endif
  );

`ifdef HAZARD_PERF_CNT_EN
  hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MulDivStartE(MulDivStartE), .MulDivUseD(MulDivUseD),
    .StallF(s2f), .StallD(s2d), .FlushE(f2e),
    .ForwardAD(f2ad), .ForwardBD(f2bd),
    .ForwardAE(f2ae), .ForwardBE(f2be), .MulDivBusy(busy2),
    .StallCycles(StallCycles2), .MulDivOps(MulDivOps2)
  );
`endif

  typedef struct {
    string      tag;
    logic       st;
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       fad;
    logic       fbd;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
    MulDivStartE = 0; MulDivUseD = 0;
  endtask

  // Queue the expectation for the inputs just driven, check it mid-cycle, advance to next cycle.
  task automatic step(input string tag, input logic st, input logic [1:0] fae, input logic [1:0] fbe,
                      input logic fad, input logic fbd, input logic busy);
    exp_t e;
    e.tag = tag; e.st = st; e.fae = fae; e.fbe = fbe; e.fad = fad; e.fbd = fbd; e.busy = busy;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_StallF"},     32'(StallF),     32'(e.st));
      chk({e.tag, "_StallD"},     32'(StallD),     32'(e.st));
      chk({e.tag, "_FlushE"},     32'(FlushE),     32'(e.st));
      chk({e.tag, "_ForwardAE"},  32'(ForwardAE),  32'(e.fae));
      chk({e.tag, "_ForwardBE"},  32'(ForwardBE),  32'(e.fbe));
      chk({e.tag, "_ForwardAD"},  32'(ForwardAD),  32'(e.fad));
      chk({e.tag, "_ForwardBD"},  32'(ForwardBD),  32'(e.fbd));
      chk({e.tag, "_MulDivBusy"}, 32'(MulDivBusy), 32'(e.busy));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with hazard-provoking inputs: everything must read 0.
    clr_inputs();
    reset = 1;
    MemtoRegE = 1; RtE = 8; RsD = 8; RegWriteM = 1; WriteRegM = 5; RsE = 5;
    MulDivStartE = 1; MulDivUseD = 1;
    @(posedge clk); @(posedge clk); #1;
    step("reset_held", 0, 2'b00, 2'b00, 0, 0, 0);

    reset = 0;
    clr_inputs();
    MemtoRegE = 1; RtE = 8; RsD = 8;
    step("lw_use", 1, 2'b00, 2'b00, 0, 0, 0);
    clr_inputs();
    RsE = 8; RegWriteW = 1; WriteRegW = 8;
    step("lw_fwd_wb", 0, 2'b01, 2'b00, 0, 0, 0);

    clr_inputs();
    RsE = 5; RtE = 5; RsD = 5; RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5;
    step("fwd_prio", 0, 2'b10, 2'b10, 1, 0, 0);
    clr_inputs();
    RegWriteM = 1; RegWriteW = 1;
    step("fwd_r0", 0, 2'b00, 2'b00, 0, 0, 0);
    clr_inputs();
    RsE = 7; RtE = 9; RsD = 9; RtD = 7; RegWriteM = 1; WriteRegM = 7; RegWriteW = 1; WriteRegW = 9;
    step("fwd_mix", 0, 2'b10, 2'b01, 0, 1, 0);

    clr_inputs();
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    step("br_stall_e", 1, 2'b00, 2'b00, 0, 0, 0);
    clr_inputs();
    BranchD = 1; RsD = 3; RegWriteM = 1; WriteRegM = 3;
    step("br_fwd_m", 0, 2'b00, 2'b00, 1, 0, 0);
    clr_inputs();
    BranchD = 1; RtD = 4; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 4;
    step("br_stall_ld_m", 1, 2'b00, 2'b00, 0, 1, 0);
    clr_inputs();
    BranchD = 1; RegWriteE = 1;
    step("br_r0", 0, 2'b00, 2'b00, 0, 0, 0);
    clr_inputs();
    RsD = 3; RegWriteE = 1; WriteRegE = 3;
    step("no_branch", 0, 2'b00, 2'b00, 0, 0, 0);

    // Mult/div start at t with a held HI/LO consumer: stall t..t+4, busy t+1..t+4.
    clr_inputs();
    MulDivStartE = 1; MulDivUseD = 1;
    step("md_t0", 1, 2'b00, 2'b00, 0, 0, 0);
    MulDivStartE = 0;
    step("md_t1", 1, 2'b00, 2'b00, 0, 0, 1);
    step("md_t2", 1, 2'b00, 2'b00, 0, 0, 1);
    step("md_t3", 1, 2'b00, 2'b00, 0, 0, 1);
    step("md_t4", 1, 2'b00, 2'b00, 0, 0, 1);
    step("md_t5", 0, 2'b00, 2'b00, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_cycles", StallCycles, 32'd8);
    chk("perf_muldiv_ops",   MulDivOps,   32'd1);
    chk("perf_stall_sat",    32'(StallCycles2), 32'd3);
    chk("perf_ops_w2",       32'(MulDivOps2),   32'd1);
`endif

    // Reset in the middle of BUSY aborts the operation.
    clr_inputs();
    MulDivStartE = 1;
    step("mdr_t0", 0, 2'b00, 2'b00, 0, 0, 0);
    MulDivStartE = 0;
    step("mdr_t1", 0, 2'b00, 2'b00, 0, 0, 1);
    reset = 1; MulDivUseD = 1; RsE = 5; RsD = 5; RegWriteM = 1; WriteRegM = 5;
    step("mdr_t2_rst", 0, 2'b00, 2'b00, 0, 0, 1);
    reset = 0;
    clr_inputs();
    MulDivUseD = 1;
    step("mdr_t3", 0, 2'b00, 2'b00, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_clr_stall", StallCycles, 32'd0);
    chk("perf_clr_ops",   MulDivOps,   32'd0);
`endif

    // Back-to-back start then use.
    clr_inputs();
    MulDivStartE = 1;
    step("b2b_start", 0, 2'b00, 2'b00, 0, 0, 0);
    MulDivStartE = 0; MulDivUseD = 1;
    step("b2b_use", 1, 2'b00, 2'b00, 0, 0, 1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
